// File: rtl/eject_collector.sv
// Collects router eject words from six ports into per-port queues and delivers one flit per cycle.
// Latency: 2 cycles from presentation to deliv_valid. Backpressure: deliv_ready stalls the output register; full queues drop and pulse drop_pulse.
// Optional EJECT_DROP_COUNT_EN adds a saturating 16-bit drop_count output.

module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(Depth);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
endmodule

module eject_collector #(
    parameter int PayloadWidth = 32,
    parameter int lg_numprocs  = 3,
    parameter int QDEPTH       = 4,
    localparam int FW = PayloadWidth + 50,
    localparam int VB = FW - 1,
    localparam int EW = FW + lg_numprocs
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [EW-1:0] eject_xpos,
    input  logic [EW-1:0] eject_ypos,
    input  logic [EW-1:0] eject_zpos,
    input  logic [EW-1:0] eject_xneg,
    input  logic [EW-1:0] eject_yneg,
    input  logic [EW-1:0] eject_zneg,
    output logic [FW-1:0] deliv_flit,
    output logic [2:0]    deliv_port,
    output logic          deliv_valid,
    input  logic          deliv_ready,
`ifdef EJECT_DROP_COUNT_EN
    output logic [15:0]   drop_count,
`endif
    output logic [5:0]    drop_pulse
);
    logic [EW-1:0] eject [6];
    logic [FW-1:0] fifo_dat [6];
    logic [5:0]    empty, full, push, pop, drop;
    logic [2:0]    last_grant, grant;
    logic          load;
    logic [6*lg_numprocs-1:0] unused_children;

    assign eject[0] = eject_xpos;
    assign eject[1] = eject_ypos;
    assign eject[2] = eject_zpos;
    assign eject[3] = eject_xneg;
    assign eject[4] = eject_yneg;
    assign eject[5] = eject_zneg;

    assign unused_children = {eject_zneg[EW-1:FW], eject_yneg[EW-1:FW], eject_xneg[EW-1:FW],
                              eject_zpos[EW-1:FW], eject_ypos[EW-1:FW], eject_xpos[EW-1:FW]};

    for (genvar p = 0; p < 6; p++) begin : g_port
        logic accept;
        // Opcode 2'b11 marks reduction-special words, handled elsewhere.
        assign accept  = eject[p][VB] && (eject[p][PayloadWidth+3:PayloadWidth+2] != 2'b11);
        assign push[p] = accept && (!full[p] || pop[p]);
        assign drop[p] = accept && full[p] && !pop[p];

        sync_fifo #(.Width(FW), .Depth(QDEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[p]),
            .push_dat (eject[p][FW-1:0]),
            .pop      (pop[p]),
            .pop_dat  (fifo_dat[p]),
            .empty    (empty[p]),
            .full     (full[p])
        );
    end

    always_comb begin : arb
        logic       found;
        logic [3:0] sum;
        logic [2:0] idx;
        found = 1'b0;
        grant = last_grant;
        sum   = '0;
        idx   = '0;
        for (int i = 1; i <= 6; i++) begin
            sum = {1'b0, last_grant} + 4'(i);
            idx = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign load = (!deliv_valid || deliv_ready) && (empty != 6'h3f);
    assign pop  = load ? (6'b1 << grant) : 6'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deliv_flit  <= '0;
            deliv_port  <= '0;
            deliv_valid <= 1'b0;
            last_grant  <= 3'd5;
            drop_pulse  <= '0;
        end else begin
            drop_pulse <= drop;
            if (load) begin
                deliv_flit  <= fifo_dat[grant];
                deliv_port  <= grant;
                deliv_valid <= 1'b1;
                last_grant  <= grant;
            end else if (deliv_ready) begin
                deliv_valid <= 1'b0;
            end
        end
    end

`ifdef EJECT_DROP_COUNT_EN
    logic [2:0]  drop_num;
    logic [16:0] cnt_sum;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < 6; i++) drop_num = drop_num + 3'(drop[i]);
    end

    assign cnt_sum = {1'b0, drop_count} + 17'(drop_num);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_count <= '0;
        else      drop_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_eject_collector.sv
// Directed bench for eject_collector: latency, round-robin, reduction filtering, drops and reset.
module tb_eject_collector;
    localparam int PW = 32;
    localparam int LG = 3;
    localparam int FW = PW + 50;
    localparam int VB = FW - 1;
    localparam int EW = FW + LG;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [EW-1:0] ej [6];
    logic [FW-1:0] deliv_flit;
    logic [2:0]    deliv_port;
    logic          deliv_valid;
    logic          deliv_ready = 1'b1;
    logic [5:0]    drop_pulse;
`ifdef EJECT_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eject_collector #(.PayloadWidth(PW), .lg_numprocs(LG), .QDEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .eject_xpos  (ej[0]),
        .eject_ypos  (ej[1]),
        .eject_zpos  (ej[2]),
        .eject_xneg  (ej[3]),
        .eject_yneg  (ej[4]),
        .eject_zneg  (ej[5]),
        .deliv_flit  (deliv_flit),
        .deliv_port  (deliv_port),
        .deliv_valid (deliv_valid),
        .deliv_ready (deliv_ready),
`ifdef EJECT_DROP_COUNT_EN
        .drop_count  (drop_count),
`endif
        .drop_pulse  (drop_pulse)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] mkword(input logic [31:0] pl, input logic [1:0] op);
        logic [EW-1:0] w;
        w = '0;
        w[EW-1:FW] = '1;
        w[VB] = 1'b1;
        w[PW+3:PW+2] = op;
        w[PW+4 +: 8] = pl[7:0] ^ 8'h3C;
        w[PW-1:0] = pl;
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        for (int p = 0; p < 6; p++) ej[p] = '0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [EW-1:0] w;
        clear_inputs();
        tick();
        check("rst_valid", 128'(deliv_valid), 128'(0));
        check("rst_port", 128'(deliv_port), 128'(0));
        check("rst_flit", 128'(deliv_flit), 128'(0));
        check("rst_drop", 128'(drop_pulse), 128'(0));
        tick();
        rst = 1'b1;

        // Single flit on ypos, presented in the first cycle after reset release.
        w = mkword(32'hA5A5_0001, 2'b01);
        ej[1] = w;
        tick();
        clear_inputs();
        check("single_c1_valid", 128'(deliv_valid), 128'(0));
        tick();
        check("single_c2_valid", 128'(deliv_valid), 128'(1));
        check("single_c2_port", 128'(deliv_port), 128'(1));
        check("single_c2_flit", 128'(deliv_flit), 128'(w[FW-1:0]));
        tick();
        check("single_c3_valid", 128'(deliv_valid), 128'(0));

        // All six ports at once: round-robin from port 0, back to back.
        do_reset();
        for (int p = 0; p < 6; p++) ej[p] = mkword(32'h6000_0000 + 32'(p), 2'b10);
        tick();
        clear_inputs();
        check("rr_c1_valid", 128'(deliv_valid), 128'(0));
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_valid", 128'(deliv_valid), 128'(1));
            check("rr_port", 128'(deliv_port), 128'(k));
            check("rr_payload", 128'(deliv_flit[31:0]), 128'(32'h6000_0000 + 32'(k)));
        end
        tick();
        check("rr_end_valid", 128'(deliv_valid), 128'(0));

        // Reduction-special word on zneg is ignored entirely.
        ej[5] = mkword(32'hDEAD_BEEF, 2'b11);
        tick();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            check("red_valid", 128'(deliv_valid), 128'(0));
            check("red_drop", 128'(drop_pulse), 128'(0));
            tick();
        end

        // Stalled output: six flits on xpos, sixth dropped.
        do_reset();
        deliv_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ej[0] = mkword(32'h0000_0100 + 32'(k), 2'b00);
            tick();
            check("ovf_drop_pulse", 128'(drop_pulse), 128'((k == 5) ? 6'b000001 : 6'b0));
        end
        clear_inputs();
        check("ovf_held_valid", 128'(deliv_valid), 128'(1));
        check("ovf_held_payload", 128'(deliv_flit[31:0]), 128'(32'h100));
        tick();
        check("ovf_pulse_once", 128'(drop_pulse), 128'(0));
        check("ovf_still_held", 128'(deliv_flit[31:0]), 128'(32'h100));
`ifdef EJECT_DROP_COUNT_EN
        check("ovf_drop_count", 128'(drop_count), 128'(1));
`endif
        deliv_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("ovf_out_valid", 128'(deliv_valid), 128'(1));
            check("ovf_out_port", 128'(deliv_port), 128'(0));
            check("ovf_out_payload", 128'(deliv_flit[31:0]), 128'(32'h100 + 32'(k)));
            tick();
        end
        check("ovf_drained", 128'(deliv_valid), 128'(0));

        // Full queue with same-cycle pop accepts the new write.
        do_reset();
        deliv_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ej[0] = mkword(32'h0000_0200 + 32'(k), 2'b01);
            tick();
        end
        ej[0] = mkword(32'h0000_0205, 2'b01);
        deliv_ready = 1'b1;
        check("fpop_head", 128'(deliv_flit[31:0]), 128'(32'h200));
        tick();
        clear_inputs();
        check("fpop_no_drop", 128'(drop_pulse), 128'(0));
        for (int k = 1; k < 6; k++) begin
            check("fpop_valid", 128'(deliv_valid), 128'(1));
            check("fpop_payload", 128'(deliv_flit[31:0]), 128'(32'h200 + 32'(k)));
            tick();
        end
        check("fpop_drained", 128'(deliv_valid), 128'(0));

        // Asynchronous reset mid-stream.
        ej[0] = mkword(32'h0000_0300, 2'b00);
        ej[1] = mkword(32'h0000_0301, 2'b00);
        tick();
        clear_inputs();
        tick();
        check("mid_pre_valid", 128'(deliv_valid), 128'(1));
        rst = 1'b0;
        #1;
        check("mid_async_valid", 128'(deliv_valid), 128'(0));
        check("mid_async_flit", 128'(deliv_flit), 128'(0));
        check("mid_async_port", 128'(deliv_port), 128'(0));
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_no_stale", 128'(deliv_valid), 128'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eject_collector.md
EJECT_COLLECTOR -- requirements
Module: eject_collector

Interface
REQ-001 SHALL have parameter PayloadWidth, default 32: payload field width, giving flit width FW = PayloadWidth+50 (82) and valid bit at VB = FW-1 (81).
REQ-002 SHALL have parameter lg_numprocs, default 3: children-field width, giving ejected word width EW = FW+lg_numprocs (85).
REQ-003 SHALL have parameter QDEPTH, default 4: per-port queue depth, a power of two, 2..16.
REQ-004 clk  in  1  single clock; all flops on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 eject_xpos, eject_ypos, eject_zpos, eject_xneg, eject_yneg, eject_zneg  in  EW each  router eject words; word[VB] is the valid flag.
REQ-007 deliv_flit  out  FW  delivered flit, children bits stripped.
REQ-008 deliv_port  out  3  source port: 0 xpos, 1 ypos, 2 zpos, 3 xneg, 4 yneg, 5 zneg.
REQ-009 deliv_valid  out  1  deliv_flit and deliv_port are valid.
REQ-010 deliv_ready  in  1  consumer accepts the word.
REQ-011 drop_pulse  out  6  one-cycle pulse per port when an accepted flit is dropped.

Function
REQ-012 An eject word SHALL be accepted only when word[VB]=1 and word[PayloadWidth+3:PayloadWidth+2] != 2'b11; reduction-special words go to the reduction path and are ignored here.
REQ-013 Each port SHALL own a QDEPTH-entry FIFO holding bits [FW-1:0] of accepted words, written on the rising edge that ends the presentation cycle.
REQ-014 Write to a full FIFO SHALL be dropped and SHALL pulse the port's drop_pulse bit in the next cycle; exception: full plus a same-cycle pop SHALL accept the write.
REQ-015 The output stage SHALL be one register (deliv_flit, deliv_port, deliv_valid); a transfer occurs on a rising edge with deliv_valid=1 and deliv_ready=1.
REQ-016 The output register SHALL load whenever it is empty or transferring and at least one FIFO is non-empty.
REQ-017 A load SHALL pop exactly one FIFO, selected round-robin starting at (last granted port + 1) mod 6; the last-granted pointer SHALL update only on a load.
REQ-018 While deliv_valid=1 and deliv_ready=0, deliv_flit and deliv_port SHALL hold stable.
REQ-019 Latency SHALL be two cycles: a word presented in cycle 0 to an idle block produces deliv_valid=1 in cycle 2.
REQ-020 With deliv_ready held at 1, throughput SHALL be one flit per cycle with no bubbles while any FIFO is non-empty.
REQ-021 Per-port order SHALL be preserved; no flit SHALL be duplicated.
REQ-022 FIFO pointers SHALL be log2(QDEPTH)+1 bits wide and wrap modulo 2*QDEPTH; full means equal indices with differing MSBs.

Reset
REQ-023 rst=0 SHALL immediately clear all FIFO pointers and deliv_valid, set deliv_flit=0, deliv_port=0, drop_pulse=0 and the last-granted pointer to 5 (so port 0 has first priority), and discard all queued flits.
REQ-024 Words presented in the first cycle after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro EJECT_DROP_COUNT_EN, when defined, SHALL add output drop_count (out, 16) counting all drops, saturating at 16'hFFFF and cleared by reset.
REQ-026 Without EJECT_DROP_COUNT_EN the drop_count port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 One valid non-reduction flit (payload 32'hA5A5_0001) on eject_ypos in cycle 0, ready=1 -> cycle 2: deliv_valid=1, deliv_port=1, payload A5A5_0001; cycle 3: deliv_valid=0.
REQ-028 Flits on all six ports in cycle 0, ready=1 from reset -> deliv_port sequence 0,1,2,3,4,5 in cycles 2..7, no gaps.
REQ-029 Flit on eject_zneg with opcode bits [35:34]=2'b11 -> never delivered, drop_pulse stays 0.
REQ-030 ready=0, six flits on eject_xpos in consecutive cycles, QDEPTH=4 -> first flit held in output register, four queued, sixth dropped with drop_pulse[0] high once (drop_count=1 if enabled); after ready=1 five flits delivered in order.
REQ-031 Assert rst=0 mid-stream with deliv_valid=1 -> deliv_valid=0 without a clock edge; after release no stale flit delivered.
